polmul_sequencer: RTL and testbench

Top-level phase sequencer for the Kyber polynomial-multiplication core. It accepts one host command and issues the single-cycle start pulses (`start_fntt`, `start_pwm2`, `start_intt`) to the address generator in the correct order. The address generator has no done output, so the sequencer times each phase with cycle-exact counters and waits a fixed pipeline drain between phases. It also drives the polynomial-bank select and reports busy/done to the host.

---
 rtl/polmul_pkg.sv | 41 ++++
 rtl/polmul_sequencer_phase_timer.sv | 27 ++
 rtl/polmul_sequencer.sv | 131 +++++++++++++
 tb/tb_polmul_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/polmul_pkg.sv
// rtl/polmul_pkg.sv - shared encodings and default cycle counts for the polynomial-multiplication core
package polmul_pkg;

    localparam logic [1:0] MODE_POLMUL = 2'b00;
    localparam logic [1:0] MODE_FNTT   = 2'b01;
    localparam logic [1:0] MODE_PWM    = 2'b10;
    localparam logic [1:0] MODE_INTT   = 2'b11;

    localparam logic [1:0] PHASE_FNTT = 2'd0;
    localparam logic [1:0] PHASE_PWM  = 2'd1;
    localparam logic [1:0] PHASE_INTT = 2'd2;

    localparam int NTT_CYCLES_DEFAULT   = 896;
    localparam int PWM_CYCLES_DEFAULT   = 640;
    localparam int DRAIN_CYCLES_DEFAULT = 12;

    localparam int CNT_W = 10;

    // Steps of the full polmul list; single-phase commands run a one-entry slice of it.
    localparam logic [1:0] STEP_FNTT_A = 2'd0;
    localparam logic [1:0] STEP_FNTT_B = 2'd1;
    localparam logic [1:0] STEP_PWM    = 2'd2;
    localparam logic [1:0] STEP_INTT   = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } seq_state_t;

    function automatic logic [1:0] step_phase(input logic [1:0] step);
        case (step)
            STEP_FNTT_A, STEP_FNTT_B: step_phase = PHASE_FNTT;
            STEP_PWM:                 step_phase = PHASE_PWM;
            default:                  step_phase = PHASE_INTT;
        endcase
    endfunction

endpackage

// File: rtl/polmul_sequencer_phase_timer.sv
// rtl/polmul_sequencer_phase_timer.sv - loadable 10-bit down-counter flagging its final count
module phase_timer
    import polmul_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             en,
    output logic             last
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == CNT_W'(1));

endmodule

// File: rtl/polmul_sequencer.sv
// rtl/polmul_sequencer.sv - phase sequencer issuing timed start pulses to the address generator
module polmul_sequencer
    import polmul_pkg::*;
#(
    parameter int NTT_CYCLES   = NTT_CYCLES_DEFAULT,
    parameter int PWM_CYCLES   = PWM_CYCLES_DEFAULT,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       start_fntt,
    output logic       start_pwm2,
    output logic       start_intt,
    output logic       poly_sel,
    output logic [1:0] phase,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] NTT_LEN   = CNT_W'(NTT_CYCLES);
    localparam logic [CNT_W-1:0] PWM_LEN   = CNT_W'(PWM_CYCLES);
    localparam logic [CNT_W-1:0] DRAIN_LEN = CNT_W'(DRAIN_CYCLES);

    seq_state_t       state, state_d;
    logic [1:0]       step, step_d;
    logic [1:0]       last_step, last_step_d;
    logic             tmr_load, tmr_en, tmr_last;
    logic [CNT_W-1:0] tmr_val;

    logic       busy_d, done_d, poly_sel_d;
    logic       start_fntt_d, start_pwm2_d, start_intt_d;
    logic [1:0] phase_d, ph_d;

    phase_timer u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (tmr_load),
        .load_value (tmr_val),
        .en         (tmr_en),
        .last       (tmr_last)
    );

    always_comb begin
        state_d     = state;
        step_d      = step;
        last_step_d = last_step;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LAUNCH;
                    case (mode)
                        MODE_POLMUL: begin step_d = STEP_FNTT_A; last_step_d = STEP_INTT;   end
                        MODE_FNTT:   begin step_d = STEP_FNTT_A; last_step_d = STEP_FNTT_A; end
                        MODE_PWM:    begin step_d = STEP_PWM;    last_step_d = STEP_PWM;    end
                        default:     begin step_d = STEP_INTT;   last_step_d = STEP_INTT;   end
                    endcase
                end
            end
            ST_LAUNCH: begin
                tmr_load = 1'b1;
                tmr_val  = (step_phase(step) == PHASE_PWM) ? PWM_LEN : NTT_LEN;
                state_d  = ST_RUN;
            end
            ST_RUN: begin
                tmr_en = 1'b1;
                if (tmr_last) begin
                    tmr_load = 1'b1;
                    tmr_val  = DRAIN_LEN;
                    state_d  = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                tmr_en = 1'b1;
                if (tmr_last) begin
                    if (step == last_step) begin
                        state_d = ST_DONE;
                    end else begin
                        step_d  = step + 2'd1;
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register in the same edge as the state.
    always_comb begin
        ph_d         = step_phase(step_d);
        busy_d       = (state_d == ST_LAUNCH) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d       = (state_d == ST_DONE);
        start_fntt_d = (state_d == ST_LAUNCH) && (ph_d == PHASE_FNTT);
        start_pwm2_d = (state_d == ST_LAUNCH) && (ph_d == PHASE_PWM);
        start_intt_d = (state_d == ST_LAUNCH) && (ph_d == PHASE_INTT);
        phase_d      = busy_d ? ph_d : PHASE_FNTT;
        poly_sel_d   = busy_d && (step_d == STEP_FNTT_B);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            step       <= STEP_FNTT_A;
            last_step  <= STEP_FNTT_A;
            start_fntt <= 1'b0;
            start_pwm2 <= 1'b0;
            start_intt <= 1'b0;
            poly_sel   <= 1'b0;
            phase      <= PHASE_FNTT;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_d;
            step       <= step_d;
            last_step  <= last_step_d;
            start_fntt <= start_fntt_d;
            start_pwm2 <= start_pwm2_d;
            start_intt <= start_intt_d;
            poly_sel   <= poly_sel_d;
            phase      <= phase_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_polmul_sequencer.sv
// tb/tb_polmul_sequencer.sv - directed scoreboard bench for polmul_sequencer
module tb_polmul_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, start2;
    logic [1:0] mode, mode2;
    logic       start_fntt, start_pwm2, start_intt, poly_sel, busy, done;
    logic [1:0] phase;
    logic       start_fntt2, start_pwm22, start_intt2, poly_sel2, busy2, done2;
    logic [1:0] phase2;

    typedef struct {
        int         cyc;
        logic [3:0] kind;
    } ev_t;

    localparam logic [3:0] K_FNTT = 4'b1000;
    localparam logic [3:0] K_PWM  = 4'b0100;
    localparam logic [3:0] K_INTT = 4'b0010;
    localparam logic [3:0] K_DONE = 4'b0001;

    ev_t q1[$];
    ev_t q2[$];
    int  vectors     = 0;
    int  miscompares = 0;
    int  cyc         = 0;
    int  cs;

    always #5 clk = ~clk;

    polmul_sequencer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mode       (mode),
        .start_fntt (start_fntt),
        .start_pwm2 (start_pwm2),
        .start_intt (start_intt),
        .poly_sel   (poly_sel),
        .phase      (phase),
        .busy       (busy),
        .done       (done)
    );

    polmul_sequencer #(.DRAIN_CYCLES(1)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start2),
        .mode       (mode2),
        .start_fntt (start_fntt2),
        .start_pwm2 (start_pwm22),
        .start_intt (start_intt2),
        .poly_sel   (poly_sel2),
        .phase      (phase2),
        .busy       (busy2),
        .done       (done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        ev_t        e;
        logic [3:0] ev1, ev2;
        @(negedge clk);
        cyc++;
        if (reset_n) begin
            ev1 = {start_fntt, start_pwm2, start_intt, done};
            ev2 = {start_fntt2, start_pwm22, start_intt2, done2};
            if (ev1 != 4'b0) begin
                if (q1.size() == 0) begin
                    chk("dut1_unexpected_event", 32'(ev1), 32'd0);
                end else begin
                    e = q1.pop_front();
                    chk("dut1_event_cycle", cyc, e.cyc);
                    chk("dut1_event_kind", 32'(ev1), 32'(e.kind));
                end
            end
            if (ev2 != 4'b0) begin
                if (q2.size() == 0) begin
                    chk("dut2_unexpected_event", 32'(ev2), 32'd0);
                end else begin
                    e = q2.pop_front();
                    chk("dut2_event_cycle", cyc, e.cyc);
                    chk("dut2_event_kind", 32'(ev2), 32'(e.kind));
                end
            end
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        start2  = 1'b0;
        mode    = 2'b00;
        mode2   = 2'b00;
        tick();
        tick();
        chk("reset_outputs_dut1", 32'({start_fntt, start_pwm2, start_intt, poly_sel, phase, busy, done}), 32'd0);
        chk("reset_outputs_dut2", 32'({start_fntt2, start_pwm22, start_intt2, poly_sel2, phase2, busy2, done2}), 32'd0);
        reset_n = 1'b1;
        repeat (3) tick();

        // Mode 01 on dut1 with ignored re-start, mode 10 on dut2 with one-cycle drain.
        cs = cyc;
        start = 1'b1; mode = 2'b01;
        start2 = 1'b1; mode2 = 2'b10;
        q1.push_back('{cs + 1, K_FNTT});
        q1.push_back('{cs + 910, K_DONE});
        q2.push_back('{cs + 1, K_PWM});
        q2.push_back('{cs + 643, K_DONE});
        tick();
        start = 1'b0; mode = 2'b00;
        start2 = 1'b0; mode2 = 2'b11;
        chk("m01_busy_c1", 32'(busy), 32'd1);
        chk("m01_poly_sel_c1", 32'(poly_sel), 32'd0);
        chk("m01_phase_c1", 32'(phase), 32'd0);
        chk("m10_phase_c1", 32'(phase2), 32'd1);
        run_to(cs + 500);
        start = 1'b1; mode = 2'b10;
        tick();
        start = 1'b0; mode = 2'b11;
        chk("m01_poly_sel_c501", 32'(poly_sel), 32'd0);
        run_to(cs + 642);
        chk("m10_phase_c642", 32'(phase2), 32'd1);
        chk("m10_busy_c642", 32'(busy2), 32'd1);
        run_to(cs + 643);
        chk("m10_phase_c643", 32'(phase2), 32'd0);
        chk("m10_busy_c643", 32'(busy2), 32'd0);
        run_to(cs + 909);
        chk("m01_busy_c909", 32'(busy), 32'd1);
        run_to(cs + 910);
        chk("m01_busy_c910", 32'(busy), 32'd0);
        start = 1'b1; mode = 2'b11;
        q1.push_back('{cs + 912, K_INTT});
        q1.push_back('{cs + 1821, K_DONE});
        tick();
        chk("m01_busy_c911", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        chk("relaunch_busy_c912", 32'(busy), 32'd1);
        chk("relaunch_phase_c912", 32'(phase), 32'd2);
        run_to(cs + 1825);
        chk("relaunch_queue_drained", q1.size(), 0);

        // Full polmul.
        cs = cyc;
        start = 1'b1; mode = 2'b00;
        q1.push_back('{cs + 1, K_FNTT});
        q1.push_back('{cs + 910, K_FNTT});
        q1.push_back('{cs + 1819, K_PWM});
        q1.push_back('{cs + 2472, K_INTT});
        q1.push_back('{cs + 3381, K_DONE});
        tick();
        start = 1'b0;
        run_to(cs + 909);
        chk("m00_poly_sel_c909", 32'(poly_sel), 32'd0);
        tick();
        chk("m00_poly_sel_c910", 32'(poly_sel), 32'd1);
        chk("m00_phase_c910", 32'(phase), 32'd0);
        run_to(cs + 1818);
        chk("m00_poly_sel_c1818", 32'(poly_sel), 32'd1);
        tick();
        chk("m00_poly_sel_c1819", 32'(poly_sel), 32'd0);
        chk("m00_phase_c1819", 32'(phase), 32'd1);
        run_to(cs + 2471);
        chk("m00_phase_c2471", 32'(phase), 32'd1);
        tick();
        chk("m00_phase_c2472", 32'(phase), 32'd2);
        run_to(cs + 3380);
        chk("m00_busy_c3380", 32'(busy), 32'd1);
        run_to(cs + 3381);
        chk("m00_busy_c3381", 32'(busy), 32'd0);
        repeat (3) tick();

        // Reset in the middle of the second FNTT.
        cs = cyc;
        start = 1'b1; mode = 2'b00;
        q1.push_back('{cs + 1, K_FNTT});
        q1.push_back('{cs + 910, K_FNTT});
        tick();
        start = 1'b0;
        run_to(cs + 1500);
        chk("midrun_poly_sel_c1500", 32'(poly_sel), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", 32'({start_fntt, start_pwm2, start_intt, poly_sel, phase, busy, done}), 32'd0);
        chk("midrun_queue_drained", q1.size(), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (40) tick();
        chk("post_reset_idle_busy", 32'(busy), 32'd0);
        cs = cyc;
        start = 1'b1; mode = 2'b11;
        q1.push_back('{cs + 1, K_INTT});
        q1.push_back('{cs + 910, K_DONE});
        tick();
        start = 1'b0;
        run_to(cs + 915);
        chk("post_reset_queue_drained", q1.size(), 0);

        // Back-to-back INTT with start held.
        cs = cyc;
        start = 1'b1; mode = 2'b11;
        q1.push_back('{cs + 1, K_INTT});
        q1.push_back('{cs + 910, K_DONE});
        q1.push_back('{cs + 912, K_INTT});
        q1.push_back('{cs + 1821, K_DONE});
        run_to(cs + 911);
        chk("b2b_busy_c911", 32'(busy), 32'd0);
        run_to(cs + 912);
        start = 1'b0;
        run_to(cs + 1830);

        chk("final_queue_dut1", q1.size(), 0);
        chk("final_queue_dut2", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
